// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the load/store write-back stage:
//                FSM state encoding, access size codes and the load
//                alignment check.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Write-back stage states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_COMMIT   = 2'd2
    } lsu_state_e;

    // Access size codes carried on EX_LS_size
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // A load is misaligned when its byte offset is not a multiple of 2^size
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [2:0] addr_low);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = addr_low[0];
            SIZE_W:  mis = |addr_low[1:0];
            default: mis = |addr_low;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load data alignment. Shifts the doubleword
//                read data down to the addressed byte, truncates to the
//                access size and zero- or sign-extends to XLEN.
//  Ports       : rdata      - aligned doubleword from memory
//                addr_low   - byte offset within the doubleword
//                size       - access size code (B/H/W/D)
//                is_unsigned- 1 = zero-extend, 0 = sign-extend
//                data       - extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      addr_low,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;
    logic            ext_bit;

    always_comb begin
        shifted = rdata >> {addr_low, 3'b000};
        ext_bit = 1'b0;
        data    = shifted;
        case (size)
            SIZE_B: begin
                ext_bit = ~is_unsigned & shifted[7];
                data    = {{(XLEN-8){ext_bit}}, shifted[7:0]};
            end
            SIZE_H: begin
                ext_bit = ~is_unsigned & shifted[15];
                data    = {{(XLEN-16){ext_bit}}, shifted[15:0]};
            end
            SIZE_W: begin
                ext_bit = ~is_unsigned & shifted[31];
                data    = {{(XLEN-32){ext_bit}}, shifted[31:0]};
            end
            default: begin
                data    = shifted;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_wb.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_wb
//  Description : Load/store write-back stage. Accepts one op per cycle from
//                execute, waits for memory read data on aligned loads, and
//                commits one result per cycle to the register file.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                EX_LS_*           - op from execute (valid/ready handshake)
//                mem_rvalid/rdata/rerr - memory read response
//                LS_WB_reg_*, write_data - register file write-back
//                LS_EX_fwd_*       - bypass to execute (LSU_WB_BYPASS_EN only)
//  Config      : LSU_WB_BYPASS_EN  - adds the forwarding outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_wb
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EX_LS_valid,
    input  logic [4:0]      EX_LS_rd,
    input  logic            EX_LS_dest_wen,
    input  logic            EX_LS_is_load,
    input  logic [1:0]      EX_LS_size,
    input  logic            EX_LS_unsigned,
    input  logic [2:0]      EX_LS_addr_low,
    input  logic [XLEN-1:0] EX_LS_result,
    input  logic            EX_LS_trap,
    output logic            EX_LS_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rerr,
    output logic            LS_WB_reg_ls_valid,
    output logic            LS_WB_reg_trap_valid,
    output logic [4:0]      LS_WB_reg_rd,
    output logic            LS_WB_reg_dest_wen,
    output logic [XLEN-1:0] write_data
`ifdef LSU_WB_BYPASS_EN
    ,
    output logic            LS_EX_fwd_valid,
    output logic [4:0]      LS_EX_fwd_rd,
    output logic [XLEN-1:0] LS_EX_fwd_data
`endif
);

    lsu_state_e      state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic            dest_wen_q, dest_wen_d;
    logic [1:0]      size_q, size_d;
    logic            unsigned_q, unsigned_d;
    logic [2:0]      addr_low_q, addr_low_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            accept;
    logic            misaligned;
    logic [XLEN-1:0] load_data;

    // Aligns from the captured fields so the result is registered in wdata_q
    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata       (mem_rdata),
        .addr_low    (addr_low_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .data        (load_data)
    );

    assign EX_LS_ready = (state_q != ST_WAIT_MEM);
    assign accept      = EX_LS_valid & EX_LS_ready;
    assign misaligned  = EX_LS_is_load & is_misaligned(EX_LS_size, EX_LS_addr_low);

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        dest_wen_d = dest_wen_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_low_d = addr_low_q;
        trap_d     = trap_q;
        wdata_d    = wdata_q;

        case (state_q)
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    wdata_d = load_data;
                    trap_d  = trap_q | mem_rerr;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept is only possible in IDLE or COMMIT, so it overrides the
        // COMMIT->IDLE transition for back-to-back ops.
        if (accept) begin
            rd_d       = EX_LS_rd;
            dest_wen_d = EX_LS_dest_wen;
            size_d     = EX_LS_size;
            unsigned_d = EX_LS_unsigned;
            addr_low_d = EX_LS_addr_low;
            if (EX_LS_trap || !EX_LS_is_load || misaligned) begin
                trap_d  = EX_LS_trap | misaligned;
                wdata_d = EX_LS_result;
                state_d = ST_COMMIT;
            end else begin
                trap_d  = 1'b0;
                state_d = ST_WAIT_MEM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_q       <= 5'd0;
            dest_wen_q <= 1'b0;
            size_q     <= SIZE_B;
            unsigned_q <= 1'b0;
            addr_low_q <= 3'd0;
            trap_q     <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            dest_wen_q <= dest_wen_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_low_q <= addr_low_d;
            trap_q     <= trap_d;
            wdata_q    <= wdata_d;
        end
    end

    // Strobes are qualified by COMMIT; rd and data simply hold between ops
    assign LS_WB_reg_ls_valid   = (state_q == ST_COMMIT);
    assign LS_WB_reg_trap_valid = (state_q == ST_COMMIT) & trap_q;
    assign LS_WB_reg_dest_wen   = (state_q == ST_COMMIT) & dest_wen_q;
    assign LS_WB_reg_rd         = rd_q;
    assign write_data           = wdata_q;

`ifdef LSU_WB_BYPASS_EN
    assign LS_EX_fwd_valid = (state_q == ST_COMMIT) & dest_wen_q & ~trap_q & (rd_q != 5'd0);
    assign LS_EX_fwd_rd    = rd_q;
    assign LS_EX_fwd_data  = wdata_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_wb
//  Description : Directed self-checking bench for lsu_wb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_wb;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            EX_LS_valid;
    logic [4:0]      EX_LS_rd;
    logic            EX_LS_dest_wen;
    logic            EX_LS_is_load;
    logic [1:0]      EX_LS_size;
    logic            EX_LS_unsigned;
    logic [2:0]      EX_LS_addr_low;
    logic [XLEN-1:0] EX_LS_result;
    logic            EX_LS_trap;
    logic            EX_LS_ready;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rerr;
    logic            LS_WB_reg_ls_valid;
    logic            LS_WB_reg_trap_valid;
    logic [4:0]      LS_WB_reg_rd;
    logic            LS_WB_reg_dest_wen;
    logic [XLEN-1:0] write_data;
`ifdef LSU_WB_BYPASS_EN
    logic            LS_EX_fwd_valid;
    logic [4:0]      LS_EX_fwd_rd;
    logic [XLEN-1:0] LS_EX_fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_wb #(.XLEN(XLEN)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .EX_LS_valid          (EX_LS_valid),
        .EX_LS_rd             (EX_LS_rd),
        .EX_LS_dest_wen       (EX_LS_dest_wen),
        .EX_LS_is_load        (EX_LS_is_load),
        .EX_LS_size           (EX_LS_size),
        .EX_LS_unsigned       (EX_LS_unsigned),
        .EX_LS_addr_low       (EX_LS_addr_low),
        .EX_LS_result         (EX_LS_result),
        .EX_LS_trap           (EX_LS_trap),
        .EX_LS_ready          (EX_LS_ready),
        .mem_rvalid           (mem_rvalid),
        .mem_rdata            (mem_rdata),
        .mem_rerr             (mem_rerr),
        .LS_WB_reg_ls_valid   (LS_WB_reg_ls_valid),
        .LS_WB_reg_trap_valid (LS_WB_reg_trap_valid),
        .LS_WB_reg_rd         (LS_WB_reg_rd),
        .LS_WB_reg_dest_wen   (LS_WB_reg_dest_wen),
        .write_data           (write_data)
`ifdef LSU_WB_BYPASS_EN
        ,
        .LS_EX_fwd_valid      (LS_EX_fwd_valid),
        .LS_EX_fwd_rd         (LS_EX_fwd_rd),
        .LS_EX_fwd_data       (LS_EX_fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs and samples change 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [4:0] rd, input logic wen, input logic ld,
                            input logic [1:0] sz, input logic uns, input logic [2:0] al,
                            input logic [63:0] res, input logic trap);
        EX_LS_valid    = 1'b1;
        EX_LS_rd       = rd;
        EX_LS_dest_wen = wen;
        EX_LS_is_load  = ld;
        EX_LS_size     = sz;
        EX_LS_unsigned = uns;
        EX_LS_addr_low = al;
        EX_LS_result   = res;
        EX_LS_trap     = trap;
    endtask

    initial begin
        rst = 1'b1;
        EX_LS_valid = 1'b0; EX_LS_rd = 5'd0; EX_LS_dest_wen = 1'b0; EX_LS_is_load = 1'b0;
        EX_LS_size = 2'd0; EX_LS_unsigned = 1'b0; EX_LS_addr_low = 3'd0;
        EX_LS_result = '0; EX_LS_trap = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; mem_rerr = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_ready",    {63'd0, EX_LS_ready}, 64'd1);
        check("rst_ls_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd0);
        check("rst_trap",     {63'd0, LS_WB_reg_trap_valid}, 64'd0);
        check("rst_wen",      {63'd0, LS_WB_reg_dest_wen}, 64'd0);
        check("rst_rd",       {59'd0, LS_WB_reg_rd}, 64'd0);
        check("rst_wdata",    write_data, 64'd0);

        // Non-load rd=5 result=0x1234: commit exactly one cycle later
        drive_op(5'd5, 1'b1, 1'b0, 2'd3, 1'b0, 3'd0, 64'h1234, 1'b0);
        step();
        EX_LS_valid = 1'b0;
        check("alu_ls_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd1);
        check("alu_rd",       {59'd0, LS_WB_reg_rd}, 64'd5);
        check("alu_wen",      {63'd0, LS_WB_reg_dest_wen}, 64'd1);
        check("alu_trap",     {63'd0, LS_WB_reg_trap_valid}, 64'd0);
        check("alu_wdata",    write_data, 64'h1234);
`ifdef LSU_WB_BYPASS_EN
        check("alu_fwd_valid", {63'd0, LS_EX_fwd_valid}, 64'd1);
        check("alu_fwd_rd",    {59'd0, LS_EX_fwd_rd}, 64'd5);
        check("alu_fwd_data",  LS_EX_fwd_data, 64'h1234);
`endif
        step();
        check("alu_one_cycle", {63'd0, LS_WB_reg_ls_valid}, 64'd0);

        // LB signed, addr_low=3; rvalid in the accept cycle must be ignored
        drive_op(5'd6, 1'b1, 1'b1, 2'd0, 1'b0, 3'd3, 64'h0, 1'b0);
        mem_rvalid = 1'b1; mem_rdata = 64'h1111_1111_1111_1111;
        step();
        EX_LS_valid = 1'b0; mem_rvalid = 1'b0;
        check("lb_wait_ready", {63'd0, EX_LS_ready}, 64'd0);
        check("lb_wait_noval", {63'd0, LS_WB_reg_ls_valid}, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_8000_0000;
        step();
        mem_rvalid = 1'b0; mem_rdata = '0;
        check("lb_ls_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd1);
        check("lb_wdata",    write_data, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_rd",       {59'd0, LS_WB_reg_rd}, 64'd6);
        check("lb_trap",     {63'd0, LS_WB_reg_trap_valid}, 64'd0);
        step();

        // LWU, addr_low=4
        drive_op(5'd7, 1'b1, 1'b1, 2'd2, 1'b1, 3'd4, 64'h0, 1'b0);
        step();
        EX_LS_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0000;
        step();
        mem_rvalid = 1'b0;
        check("lwu_ls_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd1);
        check("lwu_wdata",    write_data, 64'h0000_0000_DEAD_BEEF);
        step();

        // LH addr_low=1: misaligned, straight to COMMIT with trap
        drive_op(5'd8, 1'b1, 1'b1, 2'd1, 1'b0, 3'd1, 64'h40, 1'b0);
        step();
        EX_LS_valid = 1'b0;
        check("lh_mis_ls_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd1);
        check("lh_mis_trap",     {63'd0, LS_WB_reg_trap_valid}, 64'd1);
        check("lh_mis_ready",    {63'd0, EX_LS_ready}, 64'd1);
`ifdef LSU_WB_BYPASS_EN
        check("lh_mis_fwd", {63'd0, LS_EX_fwd_valid}, 64'd0);
`endif
        step();

        // rvalid while IDLE is ignored
        mem_rvalid = 1'b1; mem_rdata = 64'h55;
        step();
        mem_rvalid = 1'b0;
        check("idle_rvalid_ignored", {63'd0, LS_WB_reg_ls_valid}, 64'd0);

        // LD held three cycles, then response with rerr
        drive_op(5'd9, 1'b1, 1'b1, 2'd3, 1'b0, 3'd0, 64'h0, 1'b0);
        step();
        EX_LS_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ld_hold_ready", {63'd0, EX_LS_ready}, 64'd0);
            check("ld_hold_noval", {63'd0, LS_WB_reg_ls_valid}, 64'd0);
            step();
        end
        mem_rvalid = 1'b1; mem_rerr = 1'b1; mem_rdata = 64'hA5A5;
        step();
        mem_rvalid = 1'b0; mem_rerr = 1'b0;
        check("ld_err_ls_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd1);
        check("ld_err_trap",     {63'd0, LS_WB_reg_trap_valid}, 64'd1);
        step();

        // Four back-to-back non-loads
        for (int i = 1; i <= 4; i++) begin
            drive_op(5'(i), 1'b1, 1'b0, 2'd3, 1'b0, 3'd0, 64'(i * 32'h11), 1'b0);
            check("b2b_ready", {63'd0, EX_LS_ready}, 64'd1);
            step();
            check("b2b_ls_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd1);
            check("b2b_rd",       {59'd0, LS_WB_reg_rd}, 64'(i));
            check("b2b_wdata",    write_data, 64'(i * 32'h11));
        end
        EX_LS_valid = 1'b0;
        step();
        check("b2b_end", {63'd0, LS_WB_reg_ls_valid}, 64'd0);

        // Non-load to rd=0: commits, never forwards
        drive_op(5'd0, 1'b1, 1'b0, 2'd3, 1'b0, 3'd0, 64'h77, 1'b0);
        step();
        EX_LS_valid = 1'b0;
        check("rd0_ls_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd1);
        check("rd0_rd",       {59'd0, LS_WB_reg_rd}, 64'd0);
`ifdef LSU_WB_BYPASS_EN
        check("rd0_fwd_valid", {63'd0, LS_EX_fwd_valid}, 64'd0);
`endif
        step();

        // Reset during WAIT_MEM, then a late rvalid
        drive_op(5'd10, 1'b1, 1'b1, 2'd3, 1'b0, 3'd0, 64'h0, 1'b0);
        step();
        EX_LS_valid = 1'b0;
        check("rstw_wait", {63'd0, EX_LS_ready}, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rstw_ls_valid", {63'd0, LS_WB_reg_ls_valid}, 64'd0);
            check("rstw_trap",     {63'd0, LS_WB_reg_trap_valid}, 64'd0);
            check("rstw_wen",      {63'd0, LS_WB_reg_dest_wen}, 64'd0);
            check("rstw_rd",       {59'd0, LS_WB_reg_rd}, 64'd0);
            check("rstw_wdata",    write_data, 64'd0);
            check("rstw_ready",    {63'd0, EX_LS_ready}, 64'd1);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
